mixcol_engine: RTL and testbench

//  Sequential AES MixColumns / InvMixColumns engine for a full 128-bit state.

---
 rtl/mixcol_engine.sv | 138 +++++++++++++
 tb/tb_mixcol_engine.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mixcol_engine.sv
// rtl/mixcol_engine.sv - AES MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per clock
// Optional inverse datapath and mode register built when MIXCOL_INV_EN is defined.
module mixcol_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NCYC = 4 / COLS_PER_CYCLE;

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state;
  logic [1:0]   cnt;
  logic [127:0] work;
  logic [127:0] work_nxt;
  logic [127:0] out_q;
  logic         mode;
  logic         last_grp;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0]  a [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    r = '0;
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = xt(a[i]) ^ xt(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    return r;
  endfunction

`ifdef MIXCOL_INV_EN
  // 9/B/D/E multiples share one xtime chain per byte
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      x2 = xt(c[31-8*i -: 8]);
      x4 = xt(x2);
      x8 = xt(x4);
      m9[i] = x8 ^ c[31-8*i -: 8];
      mb[i] = x8 ^ x2 ^ c[31-8*i -: 8];
      md[i] = x8 ^ x4 ^ c[31-8*i -: 8];
      me[i] = x8 ^ x4 ^ x2;
    end
    r = '0;
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    return inv ? mix_inv(c) : mix_fwd(c);
  endfunction
`else
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    return inv ? mix_fwd(c) : mix_fwd(c);
  endfunction

  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  // Group base is always aligned, so cnt + j never wraps past column 3
  always_comb begin
    work_nxt = work;
    for (int j = 0; j < COLS_PER_CYCLE; j++)
      work_nxt[96 - 32*(int'(cnt) + j) +: 32] = mix_col(work[96 - 32*(int'(cnt) + j) +: 32], mode);
  end

  assign last_grp = (cnt == 2'(4 - COLS_PER_CYCLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
      work  <= '0;
      out_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          work  <= in_state;
          cnt   <= 2'd0;
          state <= S_RUN;
        end
        S_RUN: begin
          work <= work_nxt;
          cnt  <= cnt + 2'(COLS_PER_CYCLE);
          if (last_grp) begin
            out_q <= work_nxt;
            state <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MIXCOL_INV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        mode <= 1'b0;
    else if (state == S_IDLE && in_valid) mode <= in_inv;
  end
`else
  assign mode = 1'b0;
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_state = out_q;

endmodule

// File: tb/tb_mixcol_engine.sv
// tb/tb_mixcol_engine.sv - self-checking bench for mixcol_engine at COLS_PER_CYCLE 1, 2 and 4
module tb_mixcol_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   ir, ov, bz;
  logic [127:0] os [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mixcol_engine #(.COLS_PER_CYCLE(1)) u_c1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]), .busy(bz[0]));
  mixcol_engine #(.COLS_PER_CYCLE(2)) u_c2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]), .busy(bz[1]));
  mixcol_engine #(.COLS_PER_CYCLE(4)) u_c4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]), .busy(bz[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  // Matrix form: out[r] = sum_k coef[k] * a[(r+k) mod 4] over GF(2^8)
  function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) begin coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09; end
    else     begin coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01; end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = st[127 - 32*c - 8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[k], a[(r+k)%4]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic eff_inv(input logic inv);
`ifdef MIXCOL_INV_EN
    return inv;
`else
    return inv & 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One block on all three engines; inputs wiggle while busy, out_ready held low for hold extra cycles
  task automatic run_block(input logic [127:0] st, input logic inv, input bit wiggle, input int hold,
                           output logic [127:0] res);
    logic [127:0] exp;
    int lat [3];
    int ncyc [3];
    ncyc[0] = 4; ncyc[1] = 2; ncyc[2] = 1;
    exp = model(st, eff_inv(inv));
    chk("idle_in_ready", {125'd0, ir}, {125'd0, 3'b111});
    in_state = st; in_inv = inv; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("accepted_busy", {125'd0, bz}, {125'd0, 3'b111});
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int c = 1; c <= 5 + hold; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (lat[i] == 0 && ov[i]) lat[i] = c;
        if (lat[i] != 0) chk($sformatf("held_state_c%0d", i), os[i], exp);
      end
      chk("busy_in_ready", {125'd0, ir}, 128'd0);
      if (wiggle) begin
        in_inv = ~in_inv;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("latency_c%0d", i), 128'(lat[i]), 128'(ncyc[i] + 1));
      chk($sformatf("out_state_c%0d", i), os[i], exp);
    end
    chk("done_out_valid", {125'd0, ov}, {125'd0, 3'b111});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_in_ready", {125'd0, ir}, {125'd0, 3'b111});
    chk("handoff_out_valid", {125'd0, ov}, 128'd0);
    chk("handoff_busy", {125'd0, bz}, 128'd0);
    chk("kept_result", os[0], exp);
    res = os[0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    logic [127:0] t1_in, t1_out;
    t1_in  = 128'hdb135345_f20a225c_01010101_2d26314c;
    t1_out = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;

    repeat (2) @(negedge clk);
    chk("reset_in_ready", {125'd0, ir}, {125'd0, 3'b111});
    chk("reset_out_valid", {125'd0, ov}, 128'd0);
    chk("reset_busy", {125'd0, bz}, 128'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_out_state_c%0d", i), os[i], 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_block(t1_in, 1'b0, 1'b0, 0, res);
    chk("t1_known_answer", res, t1_out);

    run_block(t1_out, 1'b1, 1'b0, 0, res);
`ifdef MIXCOL_INV_EN
    chk("t2_known_answer", res, t1_in);
`endif

    run_block(t1_in, 1'b0, 1'b1, 7, res);

    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {125'd0, ov}, 128'd0);
    chk("midrst_in_ready", {125'd0, ir}, {125'd0, 3'b111});
    chk("midrst_busy", {125'd0, bz}, 128'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("midrst_out_state_c%0d", i), os[i], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_block({64'hc6c6c6c6_d4d4d4d5, $urandom, $urandom}, 1'b0, 1'b0, 0, res);
    chk("t5_known_answer", {64'd0, res[127:64]}, {64'd0, 64'hc6c6c6c6_d5d5d7d6});

    for (int n = 0; n < 20; n++)
      run_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1,
                $urandom_range(0, 3), res);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
